// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter feeding a registered bitwise logic unit (AND/OR/XOR/NAND).
// Optional round-robin tie-break when LOGIC_ARB_ROUND_ROBIN_EN is defined; fixed priority (req0) otherwise.
//
// state | meaning
// IDLE  | waiting for a request; grant decision made here
// EXEC  | computing result from captured operands
// RESP  | holding result until rsp_ready
module logic_unit_arbiter #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic [1:0]       cap_op;
  logic             grant_any;
  logic             pick1;

`ifdef LOGIC_ARB_ROUND_ROBIN_EN
  // last_grant=1 means requester 1 was served last, so requester 0 wins the next tie
  logic last_grant;

  assign pick1 = req1_valid && (!req0_valid || !last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant_any) begin
      last_grant <= pick1;
    end
  end
`else
  assign pick1 = req1_valid && !req0_valid;
`endif

  // Gated by rst so no grant is offered in a cycle where the edge will reset the FSM
  assign grant_any  = (state == IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready = grant_any && !pick1;
  assign req1_ready = grant_any && pick1;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cap_a    <= '0;
      cap_b    <= '0;
      cap_op   <= 2'b00;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            cap_a  <= pick1 ? req1_a  : req0_a;
            cap_b  <= pick1 ? req1_b  : req0_b;
            cap_op <= pick1 ? req1_op : req0_op;
            rsp_id <= pick1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          case (cap_op)
            2'b00:   rsp_data <= cap_a & cap_b;
            2'b01:   rsp_data <= cap_a | cap_b;
            2'b10:   rsp_data <= cap_a ^ cap_b;
            default: rsp_data <= ~(cap_a & cap_b);
          endcase
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter; expected grant order follows LOGIC_ARB_ROUND_ROBIN_EN.
module tb_logic_unit_arbiter;
  localparam int WIDTH = 18;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]       req0_op = 2'b00, req1_op = 2'b00;
  logic             rsp_valid, rsp_id, busy;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;

  int errors = 0;
  int checks = 0;

  logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 18'h0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %b want 0", rsp_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_and_req0();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 18'h3FFFF; req0_b = 18'h2AAAA; req0_op = 2'b00; rsp_ready = 1'b0;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL and_grant got %b want 10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL and_exec got valid=%b busy=%b want valid=0 busy=1", rsp_valid, busy); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL and_latency got valid=%b want 1", rsp_valid); end
    checks++; if (rsp_data !== 18'h2AAAA) begin errors++; $display("FAIL and_data got %h want 2aaaa", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL and_id got %b want 0", rsp_id); end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL and_idle got busy=%b valid=%b want 0 0", busy, rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_xor_req1_early_ready();
    @(negedge clk);
    rsp_ready = 1'b1;
    req1_valid = 1'b1; req1_a = 18'h15555; req1_b = 18'h2AAAA; req1_op = 2'b10;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL xor_grant got %b want 01", {req0_ready, req1_ready}); end
    @(negedge clk);
    req1_valid = 1'b0; req1_a = 18'h0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL xor_early_ready got valid=%b busy=%b want 0 1", rsp_valid, busy); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 18'h3FFFF || rsp_id !== 1'b1) begin
      errors++; $display("FAIL xor_resp got valid=%b data=%h id=%b want 1 3ffff 1", rsp_valid, rsp_data, rsp_id);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL xor_idle got busy=%b want 0", busy); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_ops();
    logic [WIDTH-1:0] ta [4] = '{18'h00000, 18'h00001, 18'h3C3C3, 18'h0F0F0};
    logic [WIDTH-1:0] tb [4] = '{18'h3FFFF, 18'h20000, 18'h0F0F0, 18'h3C3C3};
    logic [1:0]       top[4] = '{2'b11, 2'b01, 2'b11, 2'b00};
    logic [WIDTH-1:0] te [4] = '{18'h3FFFF, 18'h20001, 18'h33F3F, 18'h0C0C0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_a = ta[i]; req0_b = tb[i]; req0_op = top[i]; rsp_ready = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== te[i]) begin
        errors++; $display("FAIL ops_%0d got valid=%b data=%h want 1 %h", i, rsp_valid, rsp_data, te[i]);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_arbitration();
    logic g;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 18'h0000F; req0_b = 18'h000FF; req0_op = 2'b00;
    req1_valid = 1'b1; req1_a = 18'h000F0; req1_b = 18'h00F00; req1_op = 2'b01;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
      g = k[0];
`else
      g = 1'b0;
`endif
      #1;
      checks++; if ({req0_ready, req1_ready} !== {!g, g}) begin
        errors++; $display("FAIL arb_grant_%0d got %b want %b", k, {req0_ready, req1_ready}, {!g, g});
      end
      @(negedge clk);
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL arb_exec_ready_%0d got %b want 00", k, {req0_ready, req1_ready}); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== g || rsp_data !== (g ? 18'h00FF0 : 18'h0000F)) begin
        errors++; $display("FAIL arb_resp_%0d got valid=%b id=%b data=%h want 1 %b %h", k, rsp_valid, rsp_id, rsp_data, g, (g ? 18'h00FF0 : 18'h0000F));
      end
      if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_hold_and_abort();
    req0_valid = 1'b1; req0_a = 18'h12345; req0_b = 18'h0FF00; req0_op = 2'b10;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL hold_grant got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0; req0_a = 18'h0;
    req1_valid = 1'b1; req1_a = 18'h3FFFF; req1_b = 18'h3FFFF; req1_op = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      req0_a = 18'h1 << i; req0_valid = i[0];
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 18'h1DC45 || rsp_id !== 1'b0 || busy !== 1'b1 || {req0_ready, req1_ready} !== 2'b00) begin
        errors++; $display("FAIL hold_%0d got valid=%b data=%h id=%b busy=%b ready=%b want 1 1dc45 0 1 00", i, rsp_valid, rsp_data, rsp_id, busy, {req0_ready, req1_ready});
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || {req0_ready, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL wait_grant got busy=%b ready=%b want 0 01", busy, {req0_ready, req1_ready});
    end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_in_exec got busy=%b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 18'h0 || busy !== 1'b0 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL abort got valid=%b data=%h busy=%b id=%b want 0 0 0 0", rsp_valid, rsp_data, busy, rsp_id);
    end
    rst = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL abort_no_resp_%0d got valid=%b busy=%b want 0 0", i, rsp_valid, busy);
      end
    end
    req0_valid = 1'b1; req0_a = 18'h00F0F; req0_b = 18'h0FF00; req0_op = 2'b01;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL resume_grant got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 18'h0FF0F) begin
      errors++; $display("FAIL resume_resp got valid=%b data=%h want 1 0ff0f", rsp_valid, rsp_data);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_and_req0();
    test_xor_req1_early_ready();
    test_ops();
    test_arbitration();
    test_hold_and_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
